// File: rtl/z_ctrl.sv
// z_ctrl: sequences bias load and multiply-accumulate steps for one neural-network layer over a synchronous BRAM.
// Optional macro Z_CTRL_PERF_EN enables the busy-cycle counter on cyc_cnt.
module z_ctrl #(
   parameter int AWIDTH      = 10,
   parameter int NIN         = 4,
   parameter int NNEURON     = 16,
   parameter int BIAS_BASE   = 0,
   parameter int WEIGHT_BASE = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [AWIDTH-1:0] addr,
   output logic [5:0]        k_idx,
   output logic              sel,
   output logic              enable_prev,
   output logic              enable_out,
   output logic              busy,
   output logic              z_valid,
   output logic [5:0]        z_idx,
   output logic              done,
   output logic [15:0]       cyc_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_BADDR, S_BLOAD, S_MAC, S_FB, S_ZV, S_FIN
   } state_t;

   localparam logic [5:0]        NIN_LAST = 6'(NIN - 1);
   localparam logic [5:0]        NN_LAST  = 6'(NNEURON - 1);
   localparam logic [AWIDTH-1:0] BBASE    = AWIDTH'(BIAS_BASE);
   localparam logic [AWIDTH-1:0] WBASE    = AWIDTH'(WEIGHT_BASE);

   state_t            state_q, state_d;
   logic [5:0]        i_q, i_d;
   logic [5:0]        j_q, j_d;
   logic [AWIDTH-1:0] wp_q, wp_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [5:0]        k_idx_q, k_idx_d;
   logic [5:0]        z_idx_q, z_idx_d;
   logic              sel_q, sel_d;
   logic              en_prev_q, en_prev_d;
   logic              en_out_q, en_out_d;
   logic              busy_q, busy_d;
   logic              z_valid_q, z_valid_d;
   logic              done_q, done_d;

   // Controls are registered: each state's outputs appear the cycle after it,
   // which lines the BRAM read data up with the matching sel/enable strobes.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      wp_d      = wp_q;
      addr_d    = addr_q;
      k_idx_d   = k_idx_q;
      z_idx_d   = z_idx_q;
      sel_d     = 1'b0;
      en_prev_d = 1'b0;
      en_out_d  = 1'b0;
      busy_d    = 1'b0;
      z_valid_d = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BADDR;
               i_d     = '0;
               j_d     = '0;
               wp_d    = WBASE;
               busy_d  = 1'b1;
            end
         end
         S_BADDR: begin
            addr_d  = BBASE + AWIDTH'(j_q);
            busy_d  = 1'b1;
            state_d = S_BLOAD;
         end
         S_BLOAD: begin
            sel_d     = 1'b1;
            en_prev_d = 1'b1;
            addr_d    = wp_q;
            busy_d    = 1'b1;
            state_d   = S_MAC;
         end
         S_MAC: begin
            en_out_d = 1'b1;
            k_idx_d  = i_q;
            busy_d   = 1'b1;
            state_d  = (i_q == NIN_LAST) ? S_ZV : S_FB;
         end
         S_FB: begin
            en_prev_d = 1'b1;
            addr_d    = wp_q + 1'b1;
            wp_d      = wp_q + 1'b1;
            i_d       = i_q + 6'd1;
            busy_d    = 1'b1;
            state_d   = S_MAC;
         end
         S_ZV: begin
            z_valid_d = 1'b1;
            z_idx_d   = j_q;
            wp_d      = wp_q + 1'b1;
            busy_d    = 1'b1;
            if (j_q == NN_LAST) begin
               state_d = S_FIN;
            end else begin
               j_d     = j_q + 6'd1;
               i_d     = '0;
               state_d = S_BADDR;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         i_q       <= '0;
         j_q       <= '0;
         wp_q      <= '0;
         addr_q    <= '0;
         k_idx_q   <= '0;
         z_idx_q   <= '0;
         sel_q     <= 1'b0;
         en_prev_q <= 1'b0;
         en_out_q  <= 1'b0;
         busy_q    <= 1'b0;
         z_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         wp_q      <= wp_d;
         addr_q    <= addr_d;
         k_idx_q   <= k_idx_d;
         z_idx_q   <= z_idx_d;
         sel_q     <= sel_d;
         en_prev_q <= en_prev_d;
         en_out_q  <= en_out_d;
         busy_q    <= busy_d;
         z_valid_q <= z_valid_d;
         done_q    <= done_d;
      end
   end

`ifdef Z_CTRL_PERF_EN
   logic [15:0] cyc_cnt_q, cyc_cnt_d;

   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      if (state_q == S_IDLE && start) begin
         cyc_cnt_d = '0;
      end else if (busy_q && cyc_cnt_q != 16'hFFFF) begin
         cyc_cnt_d = cyc_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) cyc_cnt_q <= '0;
      else        cyc_cnt_q <= cyc_cnt_d;
   end

   assign cyc_cnt = cyc_cnt_q;
`else
   assign cyc_cnt = '0;
`endif

   assign addr        = addr_q;
   assign k_idx       = k_idx_q;
   assign sel         = sel_q;
   assign enable_prev = en_prev_q;
   assign enable_out  = en_out_q;
   assign busy        = busy_q;
   assign z_valid     = z_valid_q;
   assign z_idx       = z_idx_q;
   assign done        = done_q;

endmodule

// File: doc/z_ctrl.md
Z_CTRL -- requirements
Module: z_ctrl

Interface
REQ-001 Parameter AWIDTH, default 10, BRAM address width.
REQ-002 Parameter NIN, default 4, inputs (MAC terms) per neuron, range 1..64.
REQ-003 Parameter NNEURON, default 16, neurons per layer, range 1..64.
REQ-004 Parameter BIAS_BASE, default 0, BRAM address of bias for neuron 0.
REQ-005 Parameter WEIGHT_BASE, default 64, BRAM address of weight (neuron 0, input 0), row-major by neuron.
REQ-006 Port clk  input  1  single clock; all state changes on rising edge.
REQ-007 Port reset  input  1  synchronous, active-low reset.
REQ-008 Port start  input  1  one-cycle request to compute a full layer.
REQ-009 Port addr  output  AWIDTH  BRAM read address (synchronous BRAM, 1-cycle read latency).
REQ-010 Port k_idx  output  6  index of activation input to drive the z datapath k operand.
REQ-011 Port sel, enable_prev, enable_out  output  1 each  z datapath controls (sel=1 loads BRAM data into accumulator-prev register).
REQ-012 Port busy  output  1  high from cycle after accepted start until done.
REQ-013 Port z_valid  output  1  one-cycle pulse: datapath out holds z of neuron z_idx.
REQ-014 Port z_idx  output  6  neuron index qualified by z_valid.
REQ-015 Port done  output  1  one-cycle pulse after last neuron's z_valid.
REQ-016 Port cyc_cnt  output  16  busy-cycle count of most recent layer run.

Function
REQ-017 States: IDLE, BADDR, BLOAD, MAC, FB, ZV, FIN; counters i (input), j (neuron), weight pointer wp.
REQ-018 IDLE: start=1 -> BADDR, j=0, i=0, wp=WEIGHT_BASE; start ignored in every other state.
REQ-019 BADDR (1 cycle): addr=BIAS_BASE+j; all enables 0.
REQ-020 BLOAD (1 cycle): sel=1, enable_prev=1 (bias captured); addr=wp.
REQ-021 MAC: enable_out=1, sel=0, k_idx=i; if i==NIN-1 -> ZV else -> FB.
REQ-022 FB: sel=0, enable_prev=1; addr=wp+1; wp<=wp+1, i<=i+1; -> MAC.
REQ-023 ZV: z_valid=1, z_idx=j; wp<=wp+1; if j==NNEURON-1 -> FIN else j<=j+1, i<=0 -> BADDR.
REQ-024 FIN: done=1, busy=0 -> IDLE.
REQ-025 Latency: each neuron takes exactly 2*NIN+2 cycles; first z_valid 2*NIN+3 cycles after start sampled.
REQ-026 Address arithmetic modulo 2^AWIDTH; wp advances by increment only (no multiplier); weight of (j,i) read at WEIGHT_BASE+j*NIN+i.
REQ-027 Outputs sel, enable_prev, enable_out, z_valid, done are 0 in any state not listed as asserting them; addr, k_idx hold last value when not driven.
REQ-028 NIN=1: MAC directly -> ZV, FB never entered.

Reset
REQ-029 reset=0 at any rising edge, including mid-layer, -> IDLE next cycle; counters, addr, k_idx, z_idx, cyc_cnt = 0; all 1-bit outputs 0.
REQ-030 start asserted in same cycle as reset=0 is discarded.

Configuration
REQ-031 Macro Z_CTRL_PERF_EN defined: cyc_cnt clears on accepted start, increments each busy cycle, saturates at 16'hFFFF, holds after done.
REQ-032 Macro Z_CTRL_PERF_EN undefined: cyc_cnt tied to 0, no counter logic synthesised.

Verification
REQ-033 NIN=4, NNEURON=2, start pulse -> z_valid at cycles 11 and 21 after start, z_idx 0 then 1, done at 22, busy high 21 cycles.
REQ-034 Same run, address trace -> 0,64,65,66,67, then 1,68,69,70,71; enable_out 4 pulses per neuron aligned with k_idx 0..3.
REQ-035 BRAM model bias=5, weights=2, k=3 all inputs -> datapath out at z_valid = 29 per neuron.
REQ-036 reset=0 during neuron 1 MAC -> IDLE next cycle, all outputs 0; new start -> full run from neuron 0.
REQ-037 start pulsed while busy -> ignored, trace identical to REQ-034.
REQ-038 Z_CTRL_PERF_EN defined, REQ-033 stimulus -> cyc_cnt=21 after done; undefined -> cyc_cnt=0 throughout.
